// File: rtl/affine2_acc.sv
`default_nettype none
// ============================================================================
// affine2_acc : sums a bias and NUM_PART signed partial sums, then shifts and
//               clamps the total into a signed 4-bit value with a saturation flag
// Revision    : 1.0
// ============================================================================
module affine2_acc #(
  parameter int NUM_PART = 4,
  parameter int SHIFT    = 3,
  parameter int RELU     = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic signed [8:0] in_data_i,
  input  logic signed [7:0] bias_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic signed [3:0] out_data_o,
  output logic              out_sat_o
);

  localparam int              c_CW     = (NUM_PART > 1) ? $clog2(NUM_PART) : 1;
  localparam logic [c_CW-1:0] c_LAST   = c_CW'(NUM_PART - 1);
  localparam logic [0:0]      c_ST_ACC = 1'b0;
  localparam logic [0:0]      c_ST_OUT = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [c_CW-1:0]    count_q, count_d;
  logic signed [15:0] acc_q, acc_d;
  logic signed [3:0]  data_q, data_d;
  logic               sat_q, sat_d;

  logic               w_accept;
  logic               w_last;
  logic signed [15:0] w_base;
  logic signed [15:0] w_sum;
  logic signed [15:0] w_shift;
  logic signed [3:0]  w_qdata;
  logic               w_qsat;

  assign w_accept = (state_q == c_ST_ACC) && in_valid_i;
  assign w_last   = (count_q == c_LAST);

  // The first partial of a group starts from the bias instead of the stale accumulator.
  assign w_base  = (count_q == '0) ? {{8{bias_i[7]}}, bias_i} : acc_q;
  assign w_sum   = w_base + {{7{in_data_i[8]}}, in_data_i};
  assign w_shift = w_sum >>> SHIFT;

  always_comb begin
    w_qdata = w_shift[3:0];
    w_qsat  = 1'b0;
    if (RELU != 0) begin
      if (w_shift < 16'sd0) begin
        w_qdata = 4'b0000;
      end else if (w_shift > 16'sd7) begin
        w_qdata = 4'b0111;
        w_qsat  = 1'b1;
      end
    end else begin
      if (w_shift > 16'sd7) begin
        w_qdata = 4'b0111;
        w_qsat  = 1'b1;
      end else if (w_shift < -16'sd8) begin
        w_qdata = 4'b1000;
        w_qsat  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= c_ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_ACC: if (w_accept && w_last) state_d = c_ST_OUT;
      c_ST_OUT: if (out_ready_i)        state_d = c_ST_ACC;
      default:                          state_d = c_ST_ACC;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == c_ST_ACC);
    out_valid_o = (state_q == c_ST_OUT);
  end

  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    data_d  = data_q;
    sat_d   = sat_q;
    if (w_accept) begin
      acc_d = w_sum;
      if (w_last) begin
        count_d = '0;
        data_d  = w_qdata;
        sat_d   = w_qsat;
      end else begin
        count_d = count_q + c_CW'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

  assign out_data_o = data_q;
  assign out_sat_o  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_affine2_acc.sv
`default_nettype none
// ============================================================================
// tb_affine2_acc : directed bench with an arithmetic reference model for the
//                  default configuration and literal checks for RELU=0, NUM_PART=1
// Revision       : 1.0
// ============================================================================
module tb_affine2_acc;

  localparam int NP = 4;
  localparam int SH = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready, out_sat;
  logic signed [8:0] in_data;
  logic signed [7:0] bias;
  logic signed [3:0] out_data;

  logic              in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_sat_b;
  logic signed [8:0] in_data_b;
  logic signed [3:0] out_data_b;

  int checks   = 0;
  int failures = 0;

  affine2_acc #(.NUM_PART(NP), .SHIFT(SH), .RELU(1)) u_dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .bias_i     (bias),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_sat_o  (out_sat)
  );

  affine2_acc #(.NUM_PART(1), .SHIFT(3), .RELU(0)) u_dut_b (
    .clock_i    (clk),
    .reset_i    (rst),
    .in_valid_i (in_valid_b),
    .in_ready_o (in_ready_b),
    .in_data_i  (in_data_b),
    .bias_i     (8'sd0),
    .out_valid_o(out_valid_b),
    .out_ready_i(out_ready_b),
    .out_data_o (out_data_b),
    .out_sat_o  (out_sat_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: running sum of accepted values, floor-divided and clamped.
  bit m_init = 1'b0;
  bit m_out  = 1'b0;
  int m_cnt  = 0;
  int m_sum  = 0;
  int m_data = 0;
  int m_sat  = 0;
  int m_q;

  always @(negedge clk) begin
    if (m_init) begin
      chk("model in_ready",  {31'b0, in_ready},  {31'b0, !m_out});
      chk("model out_valid", {31'b0, out_valid}, {31'b0, m_out});
      chk("model out_data",  {28'b0, out_data},  m_data & 15);
      chk("model out_sat",   {31'b0, out_sat},   m_sat);
    end
    if (rst) begin
      m_init = 1'b1;
      m_out  = 1'b0;
      m_cnt  = 0;
      m_sum  = 0;
      m_data = 0;
      m_sat  = 0;
    end else if (!m_out) begin
      if (in_valid) begin
        m_sum = (m_cnt == 0) ? (int'(bias) + int'(in_data)) : (m_sum + int'(in_data));
        m_cnt++;
        if (m_cnt == NP) begin
          m_q = m_sum / (1 << SH);
          if ((m_sum % (1 << SH)) != 0 && m_sum < 0) m_q = m_q - 1;
          if (m_q < 0)      begin m_data = 0;   m_sat = 0; end
          else if (m_q > 7) begin m_data = 7;   m_sat = 1; end
          else              begin m_data = m_q; m_sat = 0; end
          m_out = 1'b1;
          m_cnt = 0;
        end
      end
    end else if (out_ready) begin
      m_out = 1'b0;
    end
  end

  task automatic send(input int d, input int b);
    in_valid = 1'b1;
    in_data  = 9'(d);
    bias     = 8'(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic group4(input int b0, input int b1, input int d0, input int d1,
                        input int d2, input int d3);
    send(d0, b0);
    send(d1, b1);
    send(d2, b1);
    send(d3, b1);
  endtask

  task automatic expect_out(input string nm, input logic [3:0] d, input logic s);
    int n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (out_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: out_valid=%b after %0d cycles", nm, out_valid, n);
    end else begin
      chk({nm, " latency"}, n, 0);
      chk({nm, " data"}, {28'b0, out_data}, {28'b0, d});
      chk({nm, " sat"},  {31'b0, out_sat},  {31'b0, s});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic send_b(input string nm, input int d, input logic [3:0] ed, input logic es);
    in_valid_b = 1'b1;
    in_data_b  = 9'(d);
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    chk({nm, " valid"}, {31'b0, out_valid_b}, 32'd1);
    chk({nm, " data"},  {28'b0, out_data_b},  {28'b0, ed});
    chk({nm, " sat"},   {31'b0, out_sat_b},   {31'b0, es});
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    out_ready_b = 1'b0;
    chk({nm, " ready after"}, {31'b0, in_ready_b}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; bias = '0; out_ready = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset out_data",  {28'b0, out_data},  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);

    group4(0, 0, 10, 20, 30, -4);
    expect_out("basic", 4'd7, 1'b0);

    group4(0, 0, 255, 255, 0, 0);
    expect_out("sat pos", 4'd7, 1'b1);
    group4(0, 0, -100, 0, 0, 0);
    expect_out("relu neg", 4'd0, 1'b0);

    group4(-16, 127, 8, 8, 8, 8);
    expect_out("bias sample", 4'd2, 1'b0);

    send(50, 0);
    send(50, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset out_valid", {31'b0, out_valid}, 32'd0);
    group4(0, 0, 8, 8, 8, 8);
    expect_out("after reset", 4'd4, 1'b0);

    group4(0, 0, 8, 8, 8, 8);
    in_valid = 1'b1;
    in_data  = 9'sd100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp out_data",  {28'b0, out_data},  32'd4);
      chk("bp in_ready",  {31'b0, in_ready},  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp in_ready after", {31'b0, in_ready}, 32'd1);
    group4(0, 0, 1, 1, 1, 5);
    expect_out("bp nothing consumed", 4'd1, 1'b0);

    send_b("b neg floor", -9,   4'hE, 1'b0);
    send_b("b neg sat",   -255, 4'h8, 1'b1);
    send_b("b pos sat",   100,  4'h7, 1'b1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/affine2_acc.md
AFFINE2_ACC -- requirements
Module: affine2_acc

Interface
REQ-001 Parameter NUM_PART, default 4: number of 9-bit partial sums combined into one output neuron value; legal range 1..32.
REQ-002 Parameter SHIFT, default 3: arithmetic right-shift applied before quantization; legal range 0..12.
REQ-003 Parameter RELU, default 1: 1 = clamp negative results to 0; 0 = signed clamp.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clock  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  partial-sum present on in_data.
REQ-008 in_ready  out  1  block can accept a partial sum this cycle.
REQ-009 in_data  in  9  signed two's-complement partial sum, as produced by the first-stage 32-input adder.
REQ-010 bias  in  8  signed bias; sampled only on acceptance of the first partial of a group.
REQ-011 out_valid  out  1  quantized result present.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 out_data  out  4  signed 4-bit quantized result, the same format as the first-stage data inputs.
REQ-014 out_sat  out  1  result was clamped to +7 or -8; qualified by out_valid.

Function
REQ-015 Accept handshake: partial accepted in a cycle where in_valid=1 and in_ready=1; no other cycle alters the accumulator.
REQ-016 States: ACC (in_ready=1, out_valid=0) and OUT (in_ready=0, out_valid=1); no other states.
REQ-017 Internal accumulator: 16-bit signed; part counter: 0..NUM_PART-1.
REQ-018 First accept of a group (count=0): acc <= sext(bias) + sext(in_data); count <= 1.
REQ-019 Subsequent accepts: acc <= acc + sext(in_data); count <= count+1.
REQ-020 With NUM_PART partials in range, the 16-bit accumulator cannot overflow; no wrap handling.
REQ-021 Accept with count=NUM_PART-1 (count=0 when NUM_PART=1) is the final accept of the group.
REQ-022 On the final accept, the block computes s = acc_next, which is acc + sext(in_data), or sext(bias) + sext(in_data) when NUM_PART=1.
REQ-023 The final accept registers out_data = quant(s) and out_sat, clears count, and enters OUT on the next cycle.
REQ-024 Latency: out_valid rises exactly 1 cycle after the final accept.
REQ-025 quant: q = s >>> SHIFT, arithmetic shift with floor rounding.
REQ-026 quant with RELU=1: q<0 -> 0 (out_sat=0); q>7 -> 7 (out_sat=1); otherwise q.
REQ-027 quant with RELU=0: q>7 -> 7; q<-8 -> -8 (out_sat=1 for both clamps); otherwise q.
REQ-028 OUT state: out_data and out_sat are held stable until out_valid and out_ready are both 1.
REQ-029 OUT state: in_valid is ignored.
REQ-030 Output handshake (out_valid and out_ready both 1): return to ACC next cycle.
REQ-031 A partial cannot be accepted in the same cycle as the output handshake.
REQ-032 in_ready and out_valid are driven directly from state registers; there is no combinational path from in_valid or out_ready to any output.

Reset
REQ-033 While reset=1 at a clock edge: state <= ACC, count <= 0, acc <= 0, out_data <= 0, out_sat <= 0.
REQ-034 out_valid=0 on the cycle following any reset edge; in_ready=1 on the first cycle after reset deasserts.
REQ-035 Reset mid-group or in OUT discards all partial and pending results, with no output produced.

Verification (NUM_PART=4, SHIFT=3, RELU=1 unless stated)
REQ-036 Basic: bias=0; partials 10,20,30,-4 -> one cycle after the 4th accept, out_valid=1, out_data=7, out_sat=0 (s=56).
REQ-037 Saturation: partials 255,255,0,0, bias=0 -> out_data=7, out_sat=1; negative case: partials -100,0,0,0 -> out_data=0, out_sat=0.
REQ-038 Bias sampling: bias=-16 at the first accept, bias changed to 127 afterwards; partials 8,8,8,8 -> out_data=2 (s=16).
REQ-039 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid, out_data and out_sat remain stable, in_ready=0, and no partial is consumed; after the handshake, in_ready=1 on the next cycle.
REQ-040 Reset mid-group: pulse reset after 2 accepts, then send partials 8,8,8,8 with bias=0 -> out_data=4, and no spurious out_valid occurs.
REQ-041 RELU=0, NUM_PART=1, SHIFT=3: bias=0, partial -9 -> out_data=-2 (floor); partial -255 -> out_data=-8, out_sat=1.
